// File: rtl/scan_sequencer_pkg.sv
// Shared types and sizes for the scan sequencer and its line-search helper.
package scan_sequencer_pkg;

  localparam int NUM_LINES = 16;
  localparam int SEL_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/scan_next_line.sv
// Combinational search over the skip mask: lowest unmasked line overall and
// lowest unmasked line strictly above the current line.
module scan_next_line
  import scan_sequencer_pkg::*;
(
  input  logic [NUM_LINES-1:0] skip_mask,
  input  logic [SEL_W-1:0]     cur,
  output logic                 above_found,
  output logic [SEL_W-1:0]     above_line,
  output logic                 low_found,
  output logic [SEL_W-1:0]     low_line
);

  // Walk downward so the last hit written is the lowest qualifying line.
  always_comb begin
    above_found = 1'b0;
    above_line  = '0;
    low_found   = 1'b0;
    low_line    = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!skip_mask[i]) begin
        low_found = 1'b1;
        low_line  = SEL_W'(i);
        if (i > int'(cur)) begin
          above_found = 1'b1;
          above_line  = SEL_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Line-scan sequencer driving a 4-to-16 decoder: dwell per line, one blank
// cycle between lines, single-sweep or continuous, with abort.
module scan_sequencer
  import scan_sequencer_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        skip_mask,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  state_t               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 mode_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [NUM_LINES-1:0] mask_q;
  logic [NUM_LINES-1:0] mask_src;
  logic                 latch;
  logic [SEL_W-1:0]     sel_d;
  logic                 en_d, busy_d, done_d, wrap_d;
  logic                 above_found, low_found;
  logic [SEL_W-1:0]     above_line, low_line;

  // The start decision must see the live mask, since it is latched on that same edge.
  assign mask_src = (state_q == IDLE) ? skip_mask : mask_q;

  scan_next_line u_next (
    .skip_mask   (mask_src),
    .cur         (sel),
    .above_found (above_found),
    .above_line  (above_line),
    .low_found   (low_found),
    .low_line    (low_line)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel;
    en_d    = 1'b0;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    latch   = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            latch = 1'b1;
            if (low_found) begin
              state_d = SCAN;
              sel_d   = low_line;
              en_d    = 1'b1;
              cnt_d   = dwell;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        SCAN: begin
          if (cnt_q == '0) begin
            state_d = BLANK;
          end else begin
            en_d  = 1'b1;
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        BLANK: begin
          if (above_found) begin
            state_d = SCAN;
            sel_d   = above_line;
            en_d    = 1'b1;
            cnt_d   = dwell_q;
          end else if (mode_q) begin
            state_d = SCAN;
            sel_d   = low_line;
            en_d    = 1'b1;
            cnt_d   = dwell_q;
            wrap_d  = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel     <= '0;
      en      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel     <= sel_d;
      en      <= en_d;
      busy    <= busy_d;
      done    <= done_d;
      wrap    <= wrap_d;
      if (latch) begin
        mode_q  <= mode;
        dwell_q <= dwell;
        mask_q  <= skip_mask;
      end
    end
  end

endmodule
